timed_updown_counter: RTL and testbench

TIMED_UPDOWN_COUNTER -- requirements
Module: timed_updown_counter

---
 rtl/timed_updown_counter.sv | 88 ++++++++
 tb/tb_timed_updown_counter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timed_updown_counter.sv
// Timed up/down counter.
// A single-clock prescaler produces a clock-enable every DIVISOR enabled
// cycles. On each such tick the counter steps up or down within
// [0, MAX_COUNT], wrapping or holding at the boundary depending on SATURATE.
// A synchronous load overrides any coincident tick.

module timed_updown_counter #(
    parameter int WIDTH     = 8,
    parameter int DIVISOR   = 100000000,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int SATURATE  = 0
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    // Prescaler width: enough bits to hold DIVISOR-1, never less than one.
    localparam int               PW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [PW-1:0]    P_LAST  = PW'(DIVISOR - 1);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    logic [PW-1:0]    p;
    logic             tick_int;
    logic             at_top;
    logic             at_bottom;
    logic             at_boundary;
    logic [WIDTH-1:0] count_step;
    logic [WIDTH-1:0] load_clamped;

    // Tick qualification, boundary detection, next step value and clamped load value.
    always_comb begin
        tick_int     = enable && !load && (p == P_LAST);
        at_top       = (count == MAX_VAL);
        at_bottom    = (count == '0);
        at_boundary  = up ? at_top : at_bottom;
        load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;
        count_step   = count;
        if (up) begin
            if (!at_top) begin
                count_step = count + 1'b1;
            end else if (SATURATE == 0) begin
                count_step = '0;
            end
        end else begin
            if (!at_bottom) begin
                count_step = count - 1'b1;
            end else if (SATURATE == 0) begin
                count_step = MAX_VAL;
            end
        end
    end

    // Prescaler: restarts on load or tick, advances only while enabled.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            p <= '0;
        end else if (load || tick_int) begin
            p <= '0;
        end else if (enable) begin
            p <= p + 1'b1;
        end
    end

    // Counter plus registered tick/terminal-count pulses; load wins over a tick.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            tick  <= 1'b0;
            tc    <= 1'b0;
        end else begin
            tick <= tick_int;
            tc   <= tick_int && at_boundary;
            if (load) begin
                count <= load_clamped;
            end else if (tick_int) begin
                count <= count_step;
            end
        end
    end

endmodule

// File: tb/tb_timed_updown_counter.sv
// Bench for timed_updown_counter: three instances (wrap, saturate, DIVISOR=1)
// share one stimulus stream; expected outputs are queued per instance and
// compared by an independent monitor one edge later.

module tb_timed_updown_counter;

    typedef struct packed {
        logic [7:0] cnt;
        logic       tick;
        logic       tc;
    } exp_t;

    logic       clk_100MHz = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       up;
    logic       load;
    logic [7:0] load_value;

    logic [3:0] count_a, count_b;
    logic [7:0] count_c;
    logic       tick_a, tick_b, tick_c;
    logic       tc_a, tc_b, tc_c;

    int tests = 0;
    int fails = 0;
    bit in_reset;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    // Reference model state: count value and enabled edges since the last tick/load.
    int m_cnt[3];
    int m_phase[3];
    int m_div[3]  = '{4, 4, 1};
    int m_max[3]  = '{9, 9, 255};
    int m_sat[3]  = '{0, 1, 0};
    int m_mask[3] = '{15, 15, 255};

    timed_updown_counter #(.WIDTH(4), .DIVISOR(4), .MAX_COUNT(9), .SATURATE(0)) dut_a (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .enable(enable), .up(up),
        .load(load), .load_value(load_value[3:0]),
        .count(count_a), .tick(tick_a), .tc(tc_a)
    );

    timed_updown_counter #(.WIDTH(4), .DIVISOR(4), .MAX_COUNT(9), .SATURATE(1)) dut_b (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .enable(enable), .up(up),
        .load(load), .load_value(load_value[3:0]),
        .count(count_b), .tick(tick_b), .tc(tc_b)
    );

    timed_updown_counter #(.WIDTH(8), .DIVISOR(1), .MAX_COUNT(255), .SATURATE(0)) dut_c (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .enable(enable), .up(up),
        .load(load), .load_value(load_value),
        .count(count_c), .tick(tick_c), .tc(tc_c)
    );

    // 100 MHz clock.
    always #5 clk_100MHz = ~clk_100MHz;

    // Behavioural model: one clock edge of counter k under the given inputs.
    function automatic exp_t predictStep(int k, bit en, bit u, bit ld, int lv);
        exp_t e;
        int   v;
        e.tick = 1'b0;
        e.tc   = 1'b0;
        if (ld) begin
            v          = lv & m_mask[k];
            m_cnt[k]   = (v > m_max[k]) ? m_max[k] : v;
            m_phase[k] = 0;
        end else if (en) begin
            m_phase[k] = m_phase[k] + 1;
            if (m_phase[k] == m_div[k]) begin
                m_phase[k] = 0;
                e.tick     = 1'b1;
                if (u) begin
                    if (m_cnt[k] == m_max[k]) begin
                        e.tc = 1'b1;
                        if (m_sat[k] == 0) m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end else begin
                    if (m_cnt[k] == 0) begin
                        e.tc = 1'b1;
                        if (m_sat[k] == 0) m_cnt[k] = m_max[k];
                    end else begin
                        m_cnt[k] = m_cnt[k] - 1;
                    end
                end
            end
        end
        e.cnt = 8'(m_cnt[k]);
        return e;
    endfunction

    task automatic resetModel();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k]   = 0;
            m_phase[k] = 0;
        end
    endtask

    task automatic checkOutput(input string name, input exp_t e,
                               input logic [7:0] c, input logic t, input logic tcv);
        tests++;
        if ({c, t, tcv} !== {e.cnt, e.tick, e.tc}) begin
            fails++;
            $display("[TB] FAIL %s @%0t: got count=%0d tick=%0b tc=%0b, expected count=%0d tick=%0b tc=%0b",
                     name, $time, c, t, tcv, e.cnt, e.tick, e.tc);
        end
    endtask

    task automatic checkReset(input string tag);
        exp_t z;
        z = '0;
        checkOutput({tag, "_a"}, z, {4'b0, count_a}, tick_a, tc_a);
        checkOutput({tag, "_b"}, z, {4'b0, count_b}, tick_b, tc_b);
        checkOutput({tag, "_c"}, z, count_c, tick_c, tc_c);
    endtask

    // Drive one cycle of inputs at the falling edge and queue the predicted outputs.
    task automatic applyStimulus(input bit en, input bit u, input bit ld, input int lv);
        @(negedge clk_100MHz);
        enable     = en;
        up         = u;
        load       = ld;
        load_value = 8'(lv);
        q_a.push_back(predictStep(0, en, u, ld, lv));
        q_b.push_back(predictStep(1, en, u, ld, lv));
        q_c.push_back(predictStep(2, en, u, ld, lv));
    endtask

    // Monitor: just after each rising edge, pop and compare what was predicted for it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_100MHz);
            #1;
            if (!in_reset) begin
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    checkOutput("dut_a", e, {4'b0, count_a}, tick_a, tc_a);
                end
                if (q_b.size() > 0) begin
                    e = q_b.pop_front();
                    checkOutput("dut_b", e, {4'b0, count_b}, tick_b, tc_b);
                end
                if (q_c.size() > 0) begin
                    e = q_c.pop_front();
                    checkOutput("dut_c", e, count_c, tick_c, tc_c);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus sequence.
    initial begin
        bit dir;
        in_reset   = 1'b1;
        reset_n    = 1'b0;
        enable     = 1'b0;
        up         = 1'b1;
        load       = 1'b0;
        load_value = '0;
        dir        = 1'b1;

        #2;
        checkReset("reset_initial");
        resetModel();
        @(negedge clk_100MHz);
        reset_n  = 1'b1;
        in_reset = 1'b0;

        // Count up through a full wrap, then down through a full wrap.
        repeat (60) applyStimulus(1'b1, 1'b1, 1'b0, 0);
        repeat (60) applyStimulus(1'b1, 1'b0, 1'b0, 0);

        // Load above MAX_COUNT, then an enable freeze in the middle of a prescale.
        applyStimulus(1'b1, 1'b1, 1'b1, 12);
        repeat (2)  applyStimulus(1'b1, 1'b1, 1'b0, 0);
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 0);
        repeat (4)  applyStimulus(1'b1, 1'b1, 1'b0, 0);

        // Load coincident with a tick edge, then downward wrap/hold from zero.
        applyStimulus(1'b1, 1'b1, 1'b1, 3);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 5);
        applyStimulus(1'b1, 1'b0, 1'b1, 0);
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 0);

        // 8-bit wrap 255 -> 0 on the DIVISOR=1 instance.
        applyStimulus(1'b1, 1'b1, 1'b1, 250);
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            applyStimulus($urandom_range(0, 7) != 0, dir, $urandom_range(0, 31) == 0,
                          int'($urandom_range(0, 255)));
        end

        // Mid-prescale asynchronous reset with count=7, p=3.
        applyStimulus(1'b1, 1'b1, 1'b1, 7);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 0);
        @(posedge clk_100MHz);
        #2;
        in_reset = 1'b1;
        enable   = 1'b0;
        load     = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        checkReset("reset_async");
        repeat (2) @(negedge clk_100MHz);
        checkReset("reset_held");
        q_a.delete();
        q_b.delete();
        q_c.delete();
        resetModel();
        reset_n  = 1'b1;
        in_reset = 1'b0;

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            applyStimulus($urandom_range(0, 7) != 0, dir, $urandom_range(0, 31) == 0,
                          int'($urandom_range(0, 255)));
        end

        @(posedge clk_100MHz);
        #2;
        tests++;
        if (q_a.size() + q_b.size() + q_c.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0",
                     q_a.size() + q_b.size() + q_c.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
